// File: rtl/ctle_interp_pkg.sv
// Shared types, default parameters and the round/saturate helper for the
// interpolated-sample CTLE bank.
package ctle_interp_pkg;

  localparam int NCH_DEF   = 4;
  localparam int W_DEF     = 16;
  localparam int CW_DEF    = 18;
  localparam int CFRAC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } rs_t;

  // Round half up at bit cfrac, then clamp to a w-bit signed range.
  function automatic rs_t round_sat(input logic signed [63:0] acc,
                                    input int cfrac, input int w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rs_t res;
    r  = (acc + (64'sd1 <<< (cfrac - 1))) >>> cfrac;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (r > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end else begin
      res.val = r;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/ctle_interp_bank_mac.sv
// One-lane combinational CTLE datapath: y = a*y_prev + b0*x + b1*x_prev,
// rounded and saturated back to W bits.
module ctle_mac
  import ctle_interp_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CW    = CW_DEF,
  parameter int CFRAC = CFRAC_DEF
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  x_prev,
  input  logic signed [W-1:0]  y_prev,
  input  logic signed [CW-1:0] a,
  input  logic signed [CW-1:0] b0,
  input  logic signed [CW-1:0] b1,
  output logic signed [W-1:0]  y,
  output logic                 sat
);

  localparam int ACCW = W + CW + 2;

  logic signed [ACCW-1:0] x_e, xp_e, yp_e, a_e, b0_e, b1_e, acc;
  rs_t  rs;
  logic unused_hi;

  // Operands are widened first so every product is formed at full precision.
  always_comb begin
    x_e  = ACCW'(x);
    xp_e = ACCW'(x_prev);
    yp_e = ACCW'(y_prev);
    a_e  = ACCW'(a);
    b0_e = ACCW'(b0);
    b1_e = ACCW'(b1);
    acc  = a_e * yp_e + b0_e * x_e + b1_e * xp_e;
    rs   = round_sat(64'(acc), CFRAC, W);
    y    = rs.val[W-1:0];
    sat  = rs.sat;
  end

  assign unused_hi = ^rs.val[63:W];

endmodule

// File: rtl/ctle_interp_bank.sv
// N-lane CTLE bank: latches one block, filters its lanes serially through a
// shared MAC while carrying x/y state across blocks, then holds the result.
module ctle_interp_bank
  import ctle_interp_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int W     = W_DEF,
  parameter int CW    = CW_DEF,
  parameter int CFRAC = CFRAC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*W-1:0]     in_data,
  input  logic signed [CW-1:0] coef_a,
  input  logic signed [CW-1:0] coef_b0,
  input  logic signed [CW-1:0] coef_b1,
  input  logic                 bypass,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*W-1:0]     out_data,
  output logic                 out_sat
);

  localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t               state;
  logic [KW-1:0]        k;
  logic [NCH*W-1:0]     in_lat;
  logic [NCH*W-1:0]     out_lanes;
  logic signed [CW-1:0] a_lat, b0_lat, b1_lat;
  logic                 byp_lat;
  logic                 sat_acc;
  logic signed [W-1:0]  x_prev, y_prev;
  logic signed [W-1:0]  x_run, y_run;

  logic signed [W-1:0]  x_cur, xp_sel, yp_sel, y_mac, y_sel;
  logic                 sat_mac, sat_sel, last_lane;

  // Lane 0 takes history from the carried state, later lanes from the previous lane.
  always_comb begin
    x_cur = in_lat[int'(k)*W +: W];
    if (k == '0) begin
      xp_sel = x_prev;
      yp_sel = y_prev;
    end else begin
      xp_sel = x_run;
      yp_sel = y_run;
    end
    if (byp_lat) begin
      y_sel   = x_cur;
      sat_sel = 1'b0;
    end else begin
      y_sel   = y_mac;
      sat_sel = sat_mac;
    end
    last_lane = (k == KW'(NCH - 1));
  end

  ctle_mac #(
    .W     (W),
    .CW    (CW),
    .CFRAC (CFRAC)
  ) u_mac (
    .x      (x_cur),
    .x_prev (xp_sel),
    .y_prev (yp_sel),
    .a      (a_lat),
    .b0     (b0_lat),
    .b1     (b1_lat),
    .y      (y_mac),
    .sat    (sat_mac)
  );

  // FSM, latches, per-lane output write and carried filter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      in_lat    <= '0;
      out_lanes <= '0;
      a_lat     <= '0;
      b0_lat    <= '0;
      b1_lat    <= '0;
      byp_lat   <= 1'b0;
      sat_acc   <= 1'b0;
      x_prev    <= '0;
      y_prev    <= '0;
      x_run     <= '0;
      y_run     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_lat  <= in_data;
            a_lat   <= coef_a;
            b0_lat  <= coef_b0;
            b1_lat  <= coef_b1;
            byp_lat <= bypass;
            k       <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          out_lanes[int'(k)*W +: W] <= y_sel;
          sat_acc <= (k == '0) ? sat_sel : (sat_acc | sat_sel);
          x_run   <= x_cur;
          y_run   <= y_sel;
          if (last_lane) begin
            k     <= '0;
            state <= OUT;
            if (!byp_lat) begin
              x_prev <= x_cur;
              y_prev <= y_mac;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign out_data  = out_lanes;
  assign out_sat   = sat_acc;

endmodule

// File: tb/tb_ctle_interp_bank.sv
// Randomised and directed bench for ctle_interp_bank with a block-level
// reference model and a per-cycle compare process.
module tb_ctle_interp_bank;

  localparam int NCH   = 4;
  localparam int W     = 16;
  localparam int CW    = 18;
  localparam int CFRAC = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*W-1:0]     in_data;
  logic signed [CW-1:0] coef_a, coef_b0, coef_b1;
  logic                 bypass;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*W-1:0]     out_data;
  logic                 out_sat;

  always #5 clk = ~clk;

  ctle_interp_bank #(.NCH(NCH), .W(W), .CW(CW), .CFRAC(CFRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_a    (coef_a),
    .coef_b0   (coef_b0),
    .coef_b1   (coef_b1),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model: cycles left in computation, output pending, carried state
  int     m_cnt = 0;
  bit     m_out = 1'b0;
  longint m_xp = 0;
  longint m_yp = 0;
  longint m_exp [NCH];
  bit     m_sat = 1'b0;
  bit     chk_en = 1'b0;

  function automatic longint lane_of(logic [NCH*W-1:0] d, int k);
    logic signed [W-1:0] v;
    v = d[k*W +: W];
    return longint'(v);
  endfunction

  function automatic logic [NCH*W-1:0] pack4(int v0, int v1, int v2, int v3);
    logic [NCH*W-1:0] d;
    d = '0;
    d[0*W +: W] = W'(v0);
    d[1*W +: W] = W'(v1);
    d[2*W +: W] = W'(v2);
    d[3*W +: W] = W'(v3);
    return d;
  endfunction

  task automatic compute_block();
    longint xp, yp, x, acc, r, hi, lo;
    xp = m_xp;
    yp = m_yp;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    m_sat = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      x = lane_of(in_data, k);
      if (bypass) begin
        m_exp[k] = x;
      end else begin
        acc = longint'(coef_a) * yp + longint'(coef_b0) * x + longint'(coef_b1) * xp;
        r = (acc + (longint'(1) << (CFRAC - 1))) >>> CFRAC;
        if (r > hi) begin r = hi; m_sat = 1'b1; end
        if (r < lo) begin r = lo; m_sat = 1'b1; end
        m_exp[k] = r;
        xp = x;
        yp = r;
      end
    end
    if (!bypass) begin
      m_xp = xp;
      m_yp = yp;
    end
  endtask

  // Advances the model using the inputs as they were at the clock edge.
  task automatic model_edge();
    if (rst) begin
      m_cnt = 0; m_out = 1'b0; m_xp = 0; m_yp = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_out = 1'b1;
    end else if (m_out) begin
      if (out_ready) m_out = 1'b0;
    end else if (in_valid) begin
      compute_block();
      m_cnt = NCH;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic chk(string nm, longint got, longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Every cycle: handshake signals always, data and sat while a block is presented.
  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (in_ready !== (m_cnt == 0 && !m_out)) begin
        n_err++;
        $display("FAIL in_ready: got %b expected %b", in_ready, (m_cnt == 0 && !m_out));
      end
      n_chk++;
      if (out_valid !== m_out) begin
        n_err++;
        $display("FAIL out_valid: got %b expected %b", out_valid, m_out);
      end
      if (m_out) begin
        for (int k = 0; k < NCH; k++) begin
          n_chk++;
          if (lane_of(out_data, k) != m_exp[k]) begin
            n_err++;
            $display("FAIL lane%0d: got %0d expected %0d", k, lane_of(out_data, k), m_exp[k]);
          end
        end
        n_chk++;
        if (out_sat !== m_sat) begin
          n_err++;
          $display("FAIL out_sat: got %b expected %b", out_sat, m_sat);
        end
      end
    end
  end

  task automatic set_coef(int a, int b0, int b1);
    coef_a  = CW'(a);
    coef_b0 = CW'(b0);
    coef_b1 = CW'(b1);
  endtask

  // Sends one block with out_ready high, returns the presented result and latency.
  task automatic run_block(input logic [NCH*W-1:0] d, input bit byp,
                           output logic [NCH*W-1:0] res, output bit sres, output int lat);
    int g;
    in_data = d; bypass = byp; in_valid = 1'b1; out_ready = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin tick(); g++; end
    tick();
    in_valid = 1'b0;
    in_data = {$urandom, $urandom};
    bypass = ~byp;
    set_coef(int'($urandom_range(0, 1000)), 7, -3);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    if (!out_valid) begin
      n_chk++; n_err++;
      $display("FAIL timeout: got no out_valid expected within %0d cycles", NCH);
    end
    res = out_data; sres = out_sat;
    tick();
  endtask

  task automatic chk_block(string nm, logic [NCH*W-1:0] res, int v0, int v1, int v2, int v3);
    chk({nm, "_l0"}, lane_of(res, 0), v0);
    chk({nm, "_l1"}, lane_of(res, 1), v1);
    chk({nm, "_l2"}, lane_of(res, 2), v2);
    chk({nm, "_l3"}, lane_of(res, 3), v3);
  endtask

  logic [NCH*W-1:0] res, held;
  bit               sres;
  int               lat;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bypass = 1'b0;
    in_data = '0; set_coef(0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk_en = 1'b1;

    // identity
    set_coef(0, 65536, 0);
    run_block(pack4(100, -200, 300, -400), 1'b0, res, sres, lat);
    chk_block("ident", res, 100, -200, 300, -400);
    chk("ident_latency", lat, NCH);

    // impulse across blocks, with a bypass block in between
    rst = 1'b1; tick(); rst = 1'b0;
    set_coef(32768, 65536, 0);
    run_block(pack4(1000, 0, 0, 0), 1'b0, res, sres, lat);
    chk_block("imp1", res, 1000, 500, 250, 125);
    set_coef(32768, 65536, 0);
    run_block(pack4(7, 8, -9, 10), 1'b1, res, sres, lat);
    chk_block("byp", res, 7, 8, -9, 10);
    chk("byp_sat", sres, 0);
    set_coef(32768, 65536, 0);
    run_block(pack4(0, 0, 0, 0), 1'b0, res, sres, lat);
    chk_block("imp2", res, 63, 32, 16, 8);

    // saturation then in-range
    set_coef(0, -131072, 0);
    run_block(pack4(20000, -20000, 1, 0), 1'b0, res, sres, lat);
    chk_block("sat", res, -32768, 32767, -2, 0);
    chk("sat_flag", sres, 1);
    set_coef(0, -131072, 0);
    run_block(pack4(5, 6, 7, 8), 1'b0, res, sres, lat);
    chk("nosat_flag", sres, 0);

    // backpressure with a new block waiting
    set_coef(16384, 32768, 16384);
    in_data = pack4(1200, -800, 400, 50); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_data = pack4(-3000, 2000, 10, 9);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stable", out_data, held);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_ready_after_hs", in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    tick();

    // reset while lane 2 is being computed
    rst = 1'b1; tick(); rst = 1'b0;
    set_coef(32768, 65536, 0);
    in_data = pack4(1000, 0, 0, 0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    tick();
    chk("midrst_no_pulse", out_valid, 0);
    run_block(pack4(1000, 0, 0, 0), 1'b0, res, sres, lat);
    chk_block("midrst_imp", res, 1000, 500, 250, 125);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = {$urandom, $urandom};
      bypass    = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_coef(int'($urandom_range(0, 98304)) - 49152,
               int'($urandom_range(0, 131071)) - 65536,
               int'($urandom_range(0, 65535)) - 32768);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
    tick(); tick();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
